// File: rtl/nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_addsub_ctrl
// Description : W-bit add/subtract using one 4-bit slice, one nibble per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   res,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] C_LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_op;
    logic            r_carry;
    logic [IW-1:0]   r_idx;

    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [4:0]      w_sum;
    logic            w_c3;

    // The single shared slice; subtraction inverts b and relies on carry preset to op.
    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4] ^ {4{r_op}};
    assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    assign w_c3    = w_a_nib[3] ^ w_b_nib[3] ^ w_sum[3];

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            done    <= 1'b0;
            res     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_carry <= op;
                        r_idx   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    res[{r_idx, 2'b00} +: 4] <= w_sum[3:0];
                    r_carry                  <= w_sum[4];
                    if (r_idx == C_LAST) begin
                        cout    <= w_sum[4];
                        ovf     <= w_c3 ^ w_sum[4];
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    // done is registered, so the pulse lands in the cycle after DONE.
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_addsub_ctrl
// Description : Randomised self-checking bench against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_addsub_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;

    int vectors;
    int errors;

    nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .res   (res),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain W-bit arithmetic, unsigned compare for borrow, sign rules for overflow.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                                  output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0] full;
        full = o ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        r = full[W-1:0];
        c = o ? (x >= y) : full[W];
        v = o ? ((x[W-1] != y[W-1]) && (r[W-1] != x[W-1]))
              : ((x[W-1] == y[W-1]) && (r[W-1] != x[W-1]));
    endfunction

    task automatic check_zero(input string name);
        vectors++;
        if ({busy, done, res, cout, ovf} !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b res=%h cout=%b ovf=%b, required all 0",
                     name, busy, done, res, cout, ovf);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                          input logic [W-1:0] er, input logic ec, input logic ev, input string name);
        int   n;
        int   bcnt;
        logic seen;
        a = ta; b = tb_v; op = top; start = 1'b1;
        n = 0; bcnt = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            start = 1'b0;
            a  = W'($urandom);
            b  = W'($urandom);
            op = 1'($urandom);
            n++;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
        end
        vectors++;
        if (!seen || n != 6) begin
            errors++;
            $display("FAIL %s_latency: done after %0d edges (seen=%b), required 6", name, n, seen);
        end
        vectors++;
        if (res !== er) begin
            errors++;
            $display("FAIL %s_res: got %h, required %h", name, res, er);
        end
        vectors++;
        if (cout !== ec || ovf !== ev) begin
            errors++;
            $display("FAIL %s_flags: cout=%b ovf=%b, required cout=%b ovf=%b", name, cout, ovf, ec, ev);
        end
        vectors++;
        if (bcnt != 5) begin
            errors++;
            $display("FAIL %s_busy: busy for %0d cycles, required 5", name, bcnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #2 rst_n = 1'b0;
        #1 check_zero("reset_async");
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("reset_idle");
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add_basic");
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, r;
        logic         o, c, v;
        for (int i = 0; i < 30; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            o = 1'($urandom);
            if (i % 5 == 0) y = x;
            model(x, y, o, r, c, v);
            run_op(x, y, o, r, c, v, "random");
        end
    endtask

    task automatic test_busy();
        int           qdue[$];
        logic [W-1:0] qres[$];
        logic         qc[$];
        logic         qv[$];
        int           next_free;
        int           dcnt;
        int           bcnt;
        int           due;
        logic [W-1:0] er;
        logic         ec, ev;
        next_free = 0; dcnt = 0; bcnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            start = (cyc < 10);
            a  = W'($urandom);
            b  = W'($urandom);
            op = 1'($urandom);
            // An operation occupies five busy cycles plus one idle cycle before the next accept.
            if (start && cyc >= next_free) begin
                model(a, b, op, er, ec, ev);
                qdue.push_back(cyc + 5);
                qres.push_back(er);
                qc.push_back(ec);
                qv.push_back(ev);
                next_free = cyc + 6;
            end
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                vectors++;
                if (qdue.size() == 0) begin
                    errors++;
                    $display("FAIL busy_extra_done: done at cycle %0d, required none", cyc);
                end else begin
                    due = qdue.pop_front();
                    er  = qres.pop_front();
                    ec  = qc.pop_front();
                    ev  = qv.pop_front();
                    if (due != cyc || res !== er || cout !== ec || ovf !== ev) begin
                        errors++;
                        $display("FAIL busy_result: cyc=%0d res=%h cout=%b ovf=%b, required cyc=%0d res=%h cout=%b ovf=%b",
                                 cyc, res, cout, ovf, due, er, ec, ev);
                    end
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (dcnt != 2) begin
            errors++;
            $display("FAIL busy_done_count: got %0d, required 2", dcnt);
        end
        vectors++;
        if (bcnt != 10) begin
            errors++;
            $display("FAIL busy_cycles: got %0d, required 10", bcnt);
        end
    endtask

    task automatic test_reset_mid();
        int dcnt;
        a = 16'hFFFF; b = 16'h1234; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_zero("reset_mid_async");
        @(negedge clk);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        vectors++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, required 0", dcnt);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r1, r2;
        logic         c1, c2, v1, v2;
        logic [W-1:0] x2, y2;
        logic         o2;
        int           first;
        int           second;
        a = W'($urandom); b = W'($urandom); op = 1'($urandom);
        model(a, b, op, r1, c1, v1);
        x2 = W'($urandom); y2 = W'($urandom); o2 = 1'($urandom);
        model(x2, y2, o2, r2, c2, v2);
        start = 1'b1;
        first = -1; second = -1;
        for (int cyc = 0; cyc < 20 && second < 0; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                if (first < 0) begin
                    first = cyc;
                    vectors++;
                    if (res !== r1 || cout !== c1 || ovf !== v1) begin
                        errors++;
                        $display("FAIL b2b_first: res=%h cout=%b ovf=%b, required %h %b %b", res, cout, ovf, r1, c1, v1);
                    end
                    a = x2; b = y2; op = o2; start = 1'b1;
                end else begin
                    second = cyc;
                    vectors++;
                    if (res !== r2 || cout !== c2 || ovf !== v2) begin
                        errors++;
                        $display("FAIL b2b_second: res=%h cout=%b ovf=%b, required %h %b %b", res, cout, ovf, r2, c2, v2);
                    end
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (first != 5 || second - first != 6) begin
            errors++;
            $display("FAIL b2b_spacing: first=%0d second=%0d, required 5 and 11", first, second);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_directed();
        test_random();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
